// File: rtl/logicnet_lut_neuron_array.sv
// Runtime-programmable array of LogicNets LUT neurons with valid/ready streaming and 1-cycle latency.
// Optional table readback port enabled by defining LOGICNET_LUT_READBACK_EN.
module logicnet_lut_neuron_array #(
    parameter int NUM_NEURONS = 4,
    parameter int IN_BITS     = 8,
    parameter int OUT_BITS    = 1,
    localparam int NW         = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [NUM_NEURONS*IN_BITS-1:0]  in_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [NUM_NEURONS*OUT_BITS-1:0] out_data,
    input  logic                            cfg_we,
    input  logic [NW-1:0]                   cfg_neuron,
    input  logic [IN_BITS-1:0]              cfg_addr,
    input  logic [OUT_BITS-1:0]             cfg_wdata,
    output logic                            cfg_ready,
    output logic                            init_done
`ifdef LOGICNET_LUT_READBACK_EN
    ,
    input  logic                            cfg_re,
    output logic                            cfg_rvalid,
    output logic [OUT_BITS-1:0]             cfg_rdata
`endif
);

    localparam int DEPTH = 1 << IN_BITS;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_e;

    state_e                          state_q, state_d;
    logic [IN_BITS-1:0]              init_cnt_q, init_cnt_d;
    logic                            out_valid_q, out_valid_d;
    logic [NUM_NEURONS*OUT_BITS-1:0] out_data_q, out_data_d;
    logic                            init_done_q, init_done_d;
    logic                            cfg_ready_q, cfg_ready_d;

    logic [NUM_NEURONS*OUT_BITS-1:0] lut_out;
    logic [NUM_NEURONS-1:0]          tbl_we;
    logic [IN_BITS-1:0]              tbl_waddr;
    logic [OUT_BITS-1:0]             tbl_wdata;
    logic                            run;
    logic                            in_fire;

`ifdef LOGICNET_LUT_READBACK_EN
    logic [OUT_BITS-1:0]             rb_word [NUM_NEURONS];
    logic                            cfg_rvalid_q, cfg_rvalid_d;
    logic [OUT_BITS-1:0]             cfg_rdata_q, cfg_rdata_d;
`endif

    assign run       = (state_q == ST_RUN);
    assign in_ready  = run && !cfg_we && (!out_valid_q || out_ready);
    assign in_fire   = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign init_done = init_done_q;
    assign cfg_ready = cfg_ready_q;

    // One distributed-RAM table per neuron: shared write port, private lookup port.
    for (genvar n = 0; n < NUM_NEURONS; n++) begin : g_neuron
        logic [OUT_BITS-1:0] tbl [DEPTH];

        always_ff @(posedge clk) begin
            if (tbl_we[n]) begin
                tbl[tbl_waddr] <= tbl_wdata;
            end
        end

        assign lut_out[n*OUT_BITS +: OUT_BITS] = tbl[in_data[n*IN_BITS +: IN_BITS]];
`ifdef LOGICNET_LUT_READBACK_EN
        assign rb_word[n] = tbl[cfg_addr];
`endif
    end

    // INIT sweeps zeros into every table at once; RUN only writes the addressed neuron.
    always_comb begin
        tbl_we    = '0;
        tbl_waddr = cfg_addr;
        tbl_wdata = cfg_wdata;
        if (state_q == ST_INIT) begin
            tbl_we    = '1;
            tbl_waddr = init_cnt_q;
            tbl_wdata = '0;
        end else if (cfg_we) begin
            for (int n = 0; n < NUM_NEURONS; n++) begin
                tbl_we[n] = (cfg_neuron == NW'(n));
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        init_done_d = init_done_q;
        cfg_ready_d = cfg_ready_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        case (state_q)
            ST_INIT: begin
                init_cnt_d = init_cnt_q + IN_BITS'(1);
                if (init_cnt_q == '1) begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                    cfg_ready_d = 1'b1;
                end
            end
            default: ;
        endcase

        // Result is captured at accept time, so later table writes never disturb a held beat.
        if (in_fire) begin
            out_valid_d = 1'b1;
            out_data_d  = lut_out;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= '0;
            init_done_q <= 1'b0;
            cfg_ready_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            init_done_q <= init_done_d;
            cfg_ready_q <= cfg_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

`ifdef LOGICNET_LUT_READBACK_EN
    assign cfg_rvalid = cfg_rvalid_q;
    assign cfg_rdata  = cfg_rdata_q;

    // A write in the same cycle suppresses the read; out-of-range neurons read back as zero.
    always_comb begin
        cfg_rvalid_d = run && cfg_re && !cfg_we;
        cfg_rdata_d  = cfg_rdata_q;
        if (cfg_rvalid_d) begin
            cfg_rdata_d = '0;
            for (int n = 0; n < NUM_NEURONS; n++) begin
                if (cfg_neuron == NW'(n)) begin
                    cfg_rdata_d = rb_word[n];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cfg_rvalid_q <= 1'b0;
            cfg_rdata_q  <= '0;
        end else begin
            cfg_rvalid_q <= cfg_rvalid_d;
            cfg_rdata_q  <= cfg_rdata_d;
        end
    end
`endif

endmodule

// File: tb/tb_logicnet_lut_neuron_array.sv
// Directed self-checking bench for logicnet_lut_neuron_array (4 neurons x 8 in bits x 1 out bit).
// Readback vectors are included when LOGICNET_LUT_READBACK_EN is defined.
module tb_logicnet_lut_neuron_array;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_data;
    logic        cfg_we;
    logic [1:0]  cfg_neuron;
    logic [7:0]  cfg_addr;
    logic        cfg_wdata;
    logic        cfg_ready;
    logic        init_done;
`ifdef LOGICNET_LUT_READBACK_EN
    logic        cfg_re;
    logic        cfg_rvalid;
    logic        cfg_rdata;
`endif

    int checks = 0;
    int errors = 0;

    logicnet_lut_neuron_array dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .cfg_we    (cfg_we),
        .cfg_neuron(cfg_neuron),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_ready (cfg_ready),
        .init_done (init_done)
`ifdef LOGICNET_LUT_READBACK_EN
        ,
        .cfg_re    (cfg_re),
        .cfg_rvalid(cfg_rvalid),
        .cfg_rdata (cfg_rdata)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [31:0] data);
        in_valid = valid;
        in_data  = data;
    endtask

    task automatic cfgWrite(input logic we, input logic [1:0] neuron, input logic [7:0] addr,
                            input logic data);
        cfg_we     = we;
        cfg_neuron = neuron;
        cfg_addr   = addr;
        cfg_wdata  = data;
    endtask

    // Counts edges from reset release until init_done rises; in_ready/cfg_ready must stay low meanwhile.
    task automatic waitInit(input string tag);
        int cnt;
        int early;
        cnt   = 0;
        early = 0;
        while (!init_done && cnt < 400) begin
            if (in_ready || cfg_ready) early++;
            cycle();
            cnt++;
        end
        checkOutput({tag, "_init_cycles"}, cnt, 256);
        checkOutput({tag, "_ready_during_init"}, early, 0);
    endtask

    initial begin
        rst_n      = 1'b0;
        out_ready  = 1'b1;
        applyStimulus(1'b1, {4{8'hC0}});
        cfgWrite(1'b0, 2'd0, 8'h00, 1'b0);
`ifdef LOGICNET_LUT_READBACK_EN
        cfg_re     = 1'b0;
`endif
        $display("[TB] reset and table clear");
        repeat (3) cycle();
        settle();
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_data", out_data, 0);
        checkOutput("rst_init_done", init_done, 0);
        checkOutput("rst_cfg_ready", cfg_ready, 0);

        rst_n = 1'b1;
        waitInit("t1");
        settle();
        checkOutput("t1_cfg_ready", cfg_ready, 1);
        checkOutput("t1_in_ready", in_ready, 1);
        cycle();
        applyStimulus(1'b0, 32'h0);
        settle();
        checkOutput("t1_out_valid", out_valid, 1);
        checkOutput("t1_lookup_cleared", out_data, 4'b0000);
        cycle();
        checkOutput("t1_drain", out_valid, 0);

        $display("[TB] program entries and look up");
        cfgWrite(1'b1, 2'd0, 8'hC0, 1'b1);
        settle();
        checkOutput("t2_in_ready_during_cfg", in_ready, 0);
        cycle();
        cfgWrite(1'b1, 2'd2, 8'h01, 1'b1);
        cycle();
        cfg_we = 1'b0;
        applyStimulus(1'b1, {8'h00, 8'h01, 8'h00, 8'hC0});
        settle();
        checkOutput("t2_in_ready", in_ready, 1);
        cycle();
        applyStimulus(1'b0, 32'h0);
        settle();
        checkOutput("t2_out_valid", out_valid, 1);
        checkOutput("t2_out_data", out_data, 4'b0101);
        cycle();
        checkOutput("t2_taken", out_valid, 0);
        checkOutput("t2_data_kept", out_data, 4'b0101);

        $display("[TB] backpressure");
        out_ready = 1'b0;
        applyStimulus(1'b1, {4{8'hC0}});
        cycle();
        applyStimulus(1'b1, {8'h00, 8'h01, 8'h00, 8'h00});
        settle();
        checkOutput("t3_a_valid", out_valid, 1);
        checkOutput("t3_a_data", out_data, 4'b0001);
        checkOutput("t3_b_stalled", in_ready, 0);
        cfgWrite(1'b1, 2'd0, 8'hC0, 1'b0);
        cycle();
        cfg_we = 1'b0;
        settle();
        checkOutput("t3_a_held_valid", out_valid, 1);
        checkOutput("t3_a_held_after_write", out_data, 4'b0001);
        out_ready = 1'b1;
        settle();
        checkOutput("t3_in_ready_on_take", in_ready, 1);
        cycle();
        applyStimulus(1'b0, 32'h0);
        settle();
        checkOutput("t3_b_valid", out_valid, 1);
        checkOutput("t3_b_data", out_data, 4'b0100);
        cycle();
        checkOutput("t3_b_taken", out_valid, 0);

        $display("[TB] config write collides with lookup");
        cfgWrite(1'b1, 2'd3, 8'h55, 1'b1);
        applyStimulus(1'b1, {8'h55, 8'h00, 8'h00, 8'h00});
        settle();
        checkOutput("t4_in_ready_blocked", in_ready, 0);
        cycle();
        cfg_we = 1'b0;
        settle();
        checkOutput("t4_no_accept", out_valid, 0);
        checkOutput("t4_in_ready_retry", in_ready, 1);
        cycle();
        applyStimulus(1'b0, 32'h0);
        settle();
        checkOutput("t4_out_valid", out_valid, 1);
        checkOutput("t4_new_value", out_data, 4'b1000);
        cycle();

`ifdef LOGICNET_LUT_READBACK_EN
        $display("[TB] table readback");
        cfgWrite(1'b1, 2'd1, 8'h3F, 1'b1);
        cycle();
        cfg_we = 1'b0;
        cfg_re = 1'b1;
        cycle();
        cfg_re = 1'b0;
        settle();
        checkOutput("t6_rvalid", cfg_rvalid, 1);
        checkOutput("t6_rdata", cfg_rdata, 1);
        cycle();
        checkOutput("t6_rvalid_pulse", cfg_rvalid, 0);
        cfg_addr = 8'h3E;
        cfg_re   = 1'b1;
        cycle();
        cfg_re = 1'b0;
        settle();
        checkOutput("t6_rdata_unwritten", cfg_rdata, 0);
        cycle();
`endif

        $display("[TB] reset during init");
        out_ready = 1'b0;
        applyStimulus(1'b1, {8'h55, 8'h01, 8'h00, 8'hC0});
        cycle();
        applyStimulus(1'b0, 32'h0);
        settle();
        checkOutput("t5_held_data", out_data, 4'b1100);
        rst_n = 1'b0;
        cycle();
        settle();
        checkOutput("t5_rst_out_valid", out_valid, 0);
        checkOutput("t5_rst_out_data", out_data, 0);
        checkOutput("t5_rst_init_done", init_done, 0);
        rst_n = 1'b1;
        repeat (100) cycle();
        checkOutput("t5_mid_init_done", init_done, 0);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        waitInit("t5");
        out_ready = 1'b1;
        applyStimulus(1'b1, {8'h55, 8'h01, 8'h00, 8'hC0});
        cycle();
        applyStimulus(1'b0, 32'h0);
        settle();
        checkOutput("t5_reinit_valid", out_valid, 1);
        checkOutput("t5_reinit_cleared", out_data, 4'b0000);
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
